// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter.
// Holds the FSM state encoding and parity-mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Even parity is the plain XOR; odd parity flips it.
    function automatic logic parity_bit(input logic xor_all, input int mode);
        return xor_all ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and async-read head.
// Occupancy uses one extra bit so full and empty are distinct.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];

    // A push is refused when full, even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with TX FIFO.
// The line and busy flag are registered one cycle behind the FSM state.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out,
    output logic                 busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
    end

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_e            state_q;
    logic [CW-1:0]        clk_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 out_q;
    logic                 busy_q;

    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 line_bit;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign out       = out_q;
    assign busy      = busy_q;
    assign bit_end   = (clk_cnt_q == CLK_LAST);
    assign last_data = (bit_cnt_q == DATA_LAST);
    assign last_stop = (bit_cnt_q == STOP_LAST);

    // Next word is taken from idle, or straight out of the last stop bit.
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) ||
                  (state_q == ST_STOP && bit_end && last_stop));

    always_comb begin
        line_bit = 1'b1;
        case (state_q)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shift_q[0];
            ST_PARITY: line_bit = par_q;
            default:   line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            out_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            out_q  <= line_bit;
            busy_q <= (state_q != ST_IDLE) || !fifo_empty;

            if (state_q == ST_IDLE || bit_end) begin
                clk_cnt_q <= '0;
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end

            if (pop) begin
                state_q   <= ST_START;
                shift_q   <= fifo_rdata;
                par_q     <= parity_bit(^fifo_rdata, PARITY);
                bit_cnt_q <= '0;
            end else if (bit_end) begin
                case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                    end
                    ST_DATA: begin
                        shift_q <= shift_q >> 1;
                        if (last_data) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (last_stop) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
